// File: rtl/controller_if.sv
// Instruction, zero flag and control word shared by the controller and its datapath.
// The controller connects through the slave modport; the driver of IR/z uses master.
interface controller_if;
    logic [15:0] IR;
    logic        z;
    logic [48:0] OPs;

    modport master (output IR, output z, input OPs);
    modport slave  (input IR, input z, output OPs);
endinterface

// File: rtl/controller.sv
// Moore FSM sequencing fetch/decode/execute and emitting a 49-bit control word per state.
// Define CONTROLLER_DEBUG_STATE_EN to expose the state code on OPs[48:43]; otherwise those bits are 0.
module controller (
    input  logic         clk,
    input  logic         rst,
    controller_if.slave  bus
);
    localparam logic [5:0] S_IDLE   = 6'd0;
    localparam logic [5:0] S_FETCH1 = 6'd1;
    localparam logic [5:0] S_FETCH2 = 6'd2;
    localparam logic [5:0] S_FETCH3 = 6'd3;
    localparam logic [5:0] S_DECODE = 6'd4;
    localparam logic [5:0] S_LDAC1  = 6'd5;
    localparam logic [5:0] S_LDAC2  = 6'd6;
    localparam logic [5:0] S_STAC1  = 6'd7;
    localparam logic [5:0] S_STAC2  = 6'd8;
    localparam logic [5:0] S_MVACR  = 6'd9;
    localparam logic [5:0] S_ADD    = 6'd10;
    localparam logic [5:0] S_SUB    = 6'd11;
    localparam logic [5:0] S_INC    = 6'd12;
    localparam logic [5:0] S_CLAC   = 6'd13;
    localparam logic [5:0] S_JUMP   = 6'd14;
    localparam logic [5:0] S_JNOT   = 6'd15;
    localparam logic [5:0] S_HALT   = 6'd63;

    localparam logic [4:0] BUS_PC  = 5'd1;
    localparam logic [4:0] BUS_DR  = 5'd2;
    localparam logic [4:0] BUS_AC  = 5'd3;
    localparam logic [4:0] BUS_R   = 5'd4;
    localparam logic [4:0] BUS_MEM = 5'd6;
    localparam logic [4:0] BUS_OPR = 5'd7;

    localparam int R_AR = 0;
    localparam int R_PC = 1;
    localparam int R_DR = 2;
    localparam int R_IR = 3;
    localparam int R_AC = 4;
    localparam int R_R  = 5;

    logic [5:0]  state_q, state_d;
    logic [3:0]  alu_op;
    logic [4:0]  bus_sel;
    logic [6:0]  ld, inc, clr;
    logic        mem_read, mem_write;
    logic [15:0] ld_f;
    logic [7:0]  inc_f, clr_f;
    logic [5:0]  state_f;
    logic        unused_operand;

    assign unused_operand = ^bus.IR[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // IR and z only influence the transition out of DECODE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.IR[7:0])
                    8'd1:    state_d = S_LDAC1;
                    8'd2:    state_d = S_STAC1;
                    8'd3:    state_d = S_MVACR;
                    8'd4:    state_d = S_ADD;
                    8'd5:    state_d = S_SUB;
                    8'd6:    state_d = S_INC;
                    8'd7:    state_d = S_CLAC;
                    8'd8:    state_d = S_JUMP;
                    8'd9:    state_d = bus.z ? S_JUMP : S_JNOT;
                    8'd21:   state_d = S_HALT;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_LDAC1:  state_d = S_LDAC2;
            S_STAC1:  state_d = S_STAC2;
            S_LDAC2, S_STAC2, S_MVACR, S_ADD, S_SUB,
            S_INC, S_CLAC, S_JUMP, S_JNOT: state_d = S_FETCH1;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op    = 4'd0;
        bus_sel   = 5'd0;
        ld        = '0;
        inc       = '0;
        clr       = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            S_FETCH1: begin bus_sel = BUS_PC;  ld[R_AR] = 1'b1; end
            S_FETCH2: begin mem_read = 1'b1; bus_sel = BUS_MEM; ld[R_DR] = 1'b1; inc[R_PC] = 1'b1; end
            S_FETCH3: begin bus_sel = BUS_DR;  ld[R_IR] = 1'b1; end
            S_DECODE: begin bus_sel = BUS_OPR; ld[R_AR] = 1'b1; end
            S_LDAC1:  begin mem_read = 1'b1; bus_sel = BUS_MEM; ld[R_DR] = 1'b1; end
            S_LDAC2:  begin bus_sel = BUS_DR;  ld[R_AC] = 1'b1; end
            S_STAC1:  begin bus_sel = BUS_AC;  ld[R_DR] = 1'b1; end
            S_STAC2:  begin bus_sel = BUS_DR;  mem_write = 1'b1; end
            S_MVACR:  begin bus_sel = BUS_AC;  ld[R_R] = 1'b1; end
            S_ADD:    begin alu_op = 4'd1; bus_sel = BUS_R; ld[R_AC] = 1'b1; end
            S_SUB:    begin alu_op = 4'd2; bus_sel = BUS_R; ld[R_AC] = 1'b1; end
            S_INC:    inc[R_AC] = 1'b1;
            S_CLAC:   clr[R_AC] = 1'b1;
            S_JUMP:   begin bus_sel = BUS_OPR; ld[R_PC] = 1'b1; end
            default:  ;
        endcase
    end

    // Widen the 7-entry register masks into their fixed-width OPs fields.
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_ld
        if (gi < 7) begin : g_used
            assign ld_f[gi] = ld[gi];
        end else begin : g_pad
            assign ld_f[gi] = 1'b0;
        end
    end
    for (gi = 0; gi < 8; gi++) begin : g_inc_clr
        if (gi < 7) begin : g_used
            assign inc_f[gi] = inc[gi];
            assign clr_f[gi] = clr[gi];
        end else begin : g_pad
            assign inc_f[gi] = 1'b0;
            assign clr_f[gi] = 1'b0;
        end
    end

`ifdef CONTROLLER_DEBUG_STATE_EN
    assign state_f = state_q;
`else
    assign state_f = 6'd0;
`endif

    assign bus.OPs = {state_f, alu_op, bus_sel, ld_f, inc_f, clr_f, mem_read, mem_write};
endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: table-driven instructions, randomized instruction stream,
// and hand-written reset/HALT sequences, all checked against a microstep-list reference model.
module tb_controller;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   exp_q[$];

    controller_if bus ();

    controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] ir;
        logic        z;
        int          n;
        logic [5:0]  e0;
        logic [5:0]  e1;
        string       name;
    } vec_t;

    vec_t vecs[13];

    // Expected control word for a state, built from the named fields of the state table.
    function automatic logic [48:0] exp_ops(input int st);
        logic [5:0]  code = 6'd0;
        logic [3:0]  alu  = 4'd0;
        logic [4:0]  bsel = 5'd0;
        logic [15:0] ld   = 16'd0;
        logic [7:0]  inc  = 8'd0;
        logic [7:0]  clr  = 8'd0;
        logic        mr   = 1'b0;
        logic        mw   = 1'b0;
        case (st)
            1:  begin bsel = 5'd1; ld[0] = 1'b1; end
            2:  begin mr = 1'b1; bsel = 5'd6; ld[2] = 1'b1; inc[1] = 1'b1; end
            3:  begin bsel = 5'd2; ld[3] = 1'b1; end
            4:  begin bsel = 5'd7; ld[0] = 1'b1; end
            5:  begin mr = 1'b1; bsel = 5'd6; ld[2] = 1'b1; end
            6:  begin bsel = 5'd2; ld[4] = 1'b1; end
            7:  begin bsel = 5'd3; ld[2] = 1'b1; end
            8:  begin bsel = 5'd2; mw = 1'b1; end
            9:  begin bsel = 5'd3; ld[5] = 1'b1; end
            10: begin alu = 4'd1; bsel = 5'd4; ld[4] = 1'b1; end
            11: begin alu = 4'd2; bsel = 5'd4; ld[4] = 1'b1; end
            12: inc[4] = 1'b1;
            13: clr[4] = 1'b1;
            14: begin bsel = 5'd7; ld[1] = 1'b1; end
            default: ;
        endcase
`ifdef CONTROLLER_DEBUG_STATE_EN
        code = 6'(st);
`endif
        return {code, alu, bsel, ld, inc, clr, mr, mw};
    endfunction

    // Reference model: an instruction is the fetch microsteps followed by its execute microsteps.
    task automatic build_seq(input logic [7:0] op, input logic zin);
        exp_q = {1, 2, 3, 4};
        case (op)
            8'd1: begin exp_q.push_back(5); exp_q.push_back(6); end
            8'd2: begin exp_q.push_back(7); exp_q.push_back(8); end
            8'd3: exp_q.push_back(9);
            8'd4: exp_q.push_back(10);
            8'd5: exp_q.push_back(11);
            8'd6: exp_q.push_back(12);
            8'd7: exp_q.push_back(13);
            8'd8: exp_q.push_back(14);
            8'd9: exp_q.push_back(zin ? 14 : 15);
            8'd21: exp_q.push_back(63);
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [48:0] exp);
        n_checks++;
        if (bus.OPs !== exp) begin
            n_errors++;
            $display("FAIL %s: OPs=%h required %h", tag, bus.OPs, exp);
        end
    endtask

    // Walk exp_q one clock per microstep; IR/z carry the real instruction only during DECODE
    // unless hold_ir is set, so any sampling outside DECODE shows up as a wrong successor.
    task automatic run_exp(input logic [15:0] ir, input logic zin, input bit hold_ir, input string tag);
        int errs0;
        errs0 = n_errors;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s step%0d state%0d", tag, i, exp_q[i]), exp_ops(exp_q[i]));
            if (hold_ir || exp_q[i] == 4) begin
                bus.IR = ir;
                bus.z  = zin;
            end else begin
                bus.IR = 16'($urandom);
                bus.z  = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        $display("instr %-6s IR=%h z=%b steps=%0d %s", tag, ir, zin, exp_q.size(),
                 (n_errors == errs0) ? "ok" : "bad");
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] ir;
        logic        zr;
        logic [48:0] held;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{16'h0501, 1'b0, 2, 6'd5,  6'd6, "LDAC"};
        vecs[1]  = '{16'h3302, 1'b1, 2, 6'd7,  6'd8, "STAC"};
        vecs[2]  = '{16'h0003, 1'b0, 1, 6'd9,  6'd0, "MVACR"};
        vecs[3]  = '{16'h0004, 1'b1, 1, 6'd10, 6'd0, "ADD"};
        vecs[4]  = '{16'h0005, 1'b0, 1, 6'd11, 6'd0, "SUB"};
        vecs[5]  = '{16'h0006, 1'b0, 1, 6'd12, 6'd0, "INC"};
        vecs[6]  = '{16'h0007, 1'b1, 1, 6'd13, 6'd0, "CLAC"};
        vecs[7]  = '{16'h2008, 1'b0, 1, 6'd14, 6'd0, "JUMP"};
        vecs[8]  = '{16'h4409, 1'b1, 1, 6'd14, 6'd0, "JMPZ1"};
        vecs[9]  = '{16'h4409, 1'b0, 1, 6'd15, 6'd0, "JMPZ0"};
        vecs[10] = '{16'h0000, 1'b0, 0, 6'd0,  6'd0, "NOP"};
        vecs[11] = '{16'h00FF, 1'b1, 0, 6'd0,  6'd0, "UNDEF"};
        vecs[12] = '{16'h0016, 1'b0, 0, 6'd0,  6'd0, "OP22"};

        rst    = 1'b1;
        bus.IR = 16'h0000;
        bus.z  = 1'b0;
        #3;
        check("reset idle", 49'd0);
        @(posedge clk); #1;
        check("reset held", 49'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            exp_q = {1, 2, 3, 4};
            if (vecs[k].n > 0) exp_q.push_back(int'(vecs[k].e0));
            if (vecs[k].n > 1) exp_q.push_back(int'(vecs[k].e1));
            run_exp(vecs[k].ir, vecs[k].z, 1'b0, vecs[k].name);
        end

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
            else                           op = 8'($urandom_range(0, 9));
            if (op == 8'd21) op = 8'd22;
            ir = {8'($urandom), op};
            zr = 1'($urandom);
            build_seq(op, zr);
            run_exp(ir, zr, 1'b0, $sformatf("rnd%0d", r));
        end

        // Reset mid-FETCH2 clears OPs at once; release restarts at FETCH1.
        check("post-random fetch1", exp_ops(1));
        @(posedge clk); #1;
        check("pre-reset fetch2", exp_ops(2));
        #2 rst = 1'b1;
        #1;
        check("async reset mid-fetch2", 49'd0);
        @(posedge clk); #1;
        check("reset held over edge", 49'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("first state after reset", exp_ops(1));
        n_checks++;
        if (bus.OPs[33:18] !== 16'h0001 || bus.OPs[38:34] !== 5'd1) begin
            n_errors++;
            $display("FAIL reset fetch1 fields: ld=%h bus_sel=%0d required ld=0001 bus_sel=1",
                     bus.OPs[33:18], bus.OPs[38:34]);
        end
        $display("reset mid-FETCH2 sequence done, errors so far %0d", n_errors);

        // IR held at END from reset onward: fetch then HALT forever despite IR/z activity.
        rst    = 1'b1;
        bus.IR = 16'd21;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        build_seq(8'd21, 1'b0);
        run_exp(16'd21, 1'b0, 1'b1, "HALT");
        held = exp_ops(63);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("halt hold c%0d", c), held);
            #2;
            bus.IR = (c % 2 == 0) ? 16'h0501 : 16'($urandom);
            bus.z  = 1'($urandom);
            #1;
            check($sformatf("halt ir toggle c%0d", c), held);
            @(posedge clk); #1;
        end
        $display("halt hold 12 cycles done, errors so far %0d", n_errors);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have: clk  input  1  rising-edge system clock.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: IR  input  16  instruction; opcode = IR[7:0], operand = IR[15:8].
REQ-004 SHALL have: z  input  1  datapath zero flag.
REQ-005 SHALL have: OPs  output  49  control word, one field set per state (REQ-007).

Function
REQ-006 SHALL be a Moore FSM with a 6-bit state register; OPs SHALL depend only on the current state, never on IR or z, so OPs changes only after a rising clk edge.
REQ-007 SHALL pack OPs fields as:
- [48:43] state code.
- [42:39] alu_op: 0 pass, 1 add, 2 sub.
- [38:34] bus_sel: 0 none, 1 PC, 2 DR, 3 AC, 4 R, 5 TR, 6 MEM, 7 IR operand.
- [33:18] ld[k], [17:10] inc[k], [9:2] clr[k].
- [1] mem_read, [0] mem_write.
- Register index k: 0 AR, 1 PC, 2 DR, 3 IR, 4 AC, 5 R, 6 TR; all other bits 0.
REQ-008 SHALL implement these states (code: asserted signals; all other OPs bits 0):
- IDLE 0: none.
- FETCH1 1: bus=PC, ld AR.
- FETCH2 2: mem_read, bus=MEM, ld DR, inc PC.
- FETCH3 3: bus=DR, ld IR.
- DECODE 4: bus=IR operand, ld AR.
- LDAC1 5: mem_read, bus=MEM, ld DR.
- LDAC2 6: bus=DR, ld AC.
- STAC1 7: bus=AC, ld DR.
- STAC2 8: bus=DR, mem_write.
- MVACR 9: bus=AC, ld R.
- ADD 10: alu_op=1, bus=R, ld AC.
- SUB 11: alu_op=2, bus=R, ld AC.
- INC 12: inc AC.
- CLAC 13: clr AC.
- JUMP 14: bus=IR operand, ld PC.
- JNOT 15: none.
- HALT 63: none.
REQ-009 SHALL sequence IDLE->FETCH1->FETCH2->FETCH3->DECODE unconditionally.
REQ-010 SHALL sample IR[7:0] and z only at the clk edge ending DECODE; IR is ignored in every other state.
REQ-011 SHALL branch from DECODE by opcode:
- 0 NOP -> FETCH1.
- 1 -> LDAC1->LDAC2.
- 2 -> STAC1->STAC2.
- 3 -> MVACR; 4 -> ADD; 5 -> SUB; 6 -> INC; 7 -> CLAC; 8 -> JUMP.
- 9 JMPZ -> JUMP if z=1, else JNOT.
- 21 END -> HALT.
- Any other opcode -> FETCH1 (treated as NOP).
REQ-012 SHALL return every terminal execute state (LDAC2, STAC2, MVACR, ADD, SUB, INC, CLAC, JUMP, JNOT) to FETCH1 on the next edge.
REQ-013 SHALL hold HALT indefinitely regardless of IR/z; only rst exits.
REQ-014 SHALL drive no unlisted state codes; an illegal state code SHALL go to IDLE on the next edge with OPs=0.

Reset
REQ-015 SHALL force state to IDLE and OPs to 0 immediately on rst=1, independent of clk.
REQ-016 SHALL, on rst deassertion, enter FETCH1 at the first following rising edge; rst mid-instruction aborts it with no partial OPs held.

Configuration
REQ-017 SHALL support macro CONTROLLER_DEBUG_STATE_EN: when defined, OPs[48:43] carries the state code; when undefined, OPs[48:43] is tied to 0 and all other fields are unchanged.

Verification
REQ-018 Reset: rst=1 mid-FETCH2 -> OPs=0 immediately; after release, next edge gives state 1 with OPs[33:18]=0x0001 and bus_sel=1.
REQ-019 IR held at 21 from the start -> fetch states 1,2,3,4, then HALT (63) held for 10+ cycles; OPs is unchanged when IR toggles mid-cycle.
REQ-020 IR=0x0501 (LDAC) -> states 1,2,3,4,5,6,1; state 5 has mem_read=1 and bus_sel=6; state 6 has ld AC (OPs bit 22)=1.
REQ-021 IR=9 with z=1 at the DECODE edge -> JUMP (14) with ld PC; repeated with z=0 -> JNOT (15) then FETCH1.
REQ-022 IR=0x00FF (undefined opcode) -> DECODE->FETCH1; IR=2 -> STAC2 has mem_write=1 (OPs[0]=1).
REQ-023 Build without CONTROLLER_DEBUG_STATE_EN -> OPs[48:43]=0 in every state; other fields identical to the debug build.
